pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipelined control unit for the 5-stage MIPS core. It decodes the decode-stage instruction word and carries the control bundle through D→E, E→M and M→W registers, so every control output lines up with the data-path stage that consumes it. Branch resolution happens in M, where zero is available, and drives the fetch-stage PC select. Stall and flush inputs insert bubbles; a bubble is an all-zero bundle.

## Interface
- No parameters.
- `clk_i` in, 1: core clock.
- `reset_i` in, 1: asynchronous, active-low reset.
- `instr_d_i` in, 32: instruction in decode stage.
- `zero_m_i` in, 1: ALU zero flag, M stage.
- `stall_d_i` in, 1: hazard stall; load-use bubble into E.
- `flush_e_i` in, 1: external flush of E stage.
- `pc_j_o` out, 1: D-stage jump select, combinational.
- `reg_dst_rtrd_e_o` out, 1: 1 selects rd, 0 selects rt.
- `b_alu_input_e_o` out, 1: 1 selects sign-extended immediate.
- `apply_shift_e_o` out, 1: shamt/rt shift operand path.
- `alu_alt_ctrl_e_o` out, 2: 00 use funct, 01 add, 10 sub, 11 reserved (treated as add).
- `mem_write_m_o` out, 1: data-memory write enable.
- `pc_beq_o` out, 1: branch taken, M stage, combinational from M register and `zero_m_i`.
- `enable_wreg_w_o` out, 1: register-file write enable.
- `mem_to_reg_w_o` out, 1: 1 selects read data.
- `illegal_d_o` out, 1: D-stage opcode/funct unsupported, combinational.

## Operation
- Decode by opcode:
  - R-type: reg_dst=1, wreg=1, alt=00. sll (funct 000000) and srl (000010) also set apply_shift=1 and b_alu_input=0.
  - lw (100011): b_alu=1, alt=01, wreg=1, mem_to_reg=1.
  - sw (101011): b_alu=1, alt=01, mem_write=1.
  - addi (001000): b_alu=1, alt=01, wreg=1.
  - beq (000100) and bne (000101): alt=10, branch=1; bne additionally sets bne=1.
  - j (000010): pc_j_o=1. No later-stage effects; the bundle is a bubble.
- Unsupported opcode or R-type funct → illegal_d_o=1. The bundle is forced to a bubble.
- Branch taken: `pc_beq_o = branch_m & (zero_m_i ^ bne_m)`.
- Register updates each edge:
  - E ← decoded bundle, or a bubble if `stall_d_i | flush_e_i | pc_beq_o`.
  - M ← E, or a bubble if `pc_beq_o`.
  - W ← M always.
- Priority: flush and branch bubbles take precedence over stall. Simultaneous stall and taken branch → E and M both get bubbles.
- While `pc_beq_o`=1, pc_j_o is ignored by the bubble logic. PC precedence between the two selects is the data path's concern.

## Timing
- Reset (reset_i=0, asynchronous) clears E/M/W to bubbles. All registered outputs read 0 immediately; pc_beq_o=0.
- Combinational D outputs (pc_j_o, illegal_d_o) follow instr_d_i even during reset.
- An instruction in D at edge n:
  - E outputs valid in cycle n+1.
  - mem_write and pc_beq valid in cycle n+2.
  - W outputs valid in cycle n+3.
- A taken branch costs 3 cycles: D, E and M bubbles. The D-stage flush is handled by the hazard unit.
- Reset deasserted mid-pipeline: refill starts from bubbles. No partial bundles survive.

## Structure
- Package `mips_ctrl_pkg`:
  - opcode and funct constants;
  - alt_ctrl encoding;
  - packed structs `ctrl_e_t`, `ctrl_m_t`, `ctrl_w_t`, each with a `BUBBLE` constant of all zeros.
- Sub-module `main_dec`: purely combinational decoder from instr[31:26] and instr[5:0] to the full bundle plus illegal.
- `pipe_ctrl` instantiates `main_dec` and holds the three stage registers and the branch logic.

## Test plan
- Reset: hold reset_i=0, instr_d_i=0x2008_0005 → all E/M/W outputs 0. After release, addi shows b_alu=1, alt=01 in E at n+1 and wreg=1 in W at n+3.
- lw 0x8C09_0004 then sw 0xAC09_0008 back-to-back:
  - W for lw has mem_to_reg=1, wreg=1;
  - M for sw has mem_write=1, and W for sw has wreg=0.
- beq 0x1109_0002 with zero_m_i=1 in M → pc_beq_o=1 for one cycle. The next edge loads bubbles into E and M. With zero_m_i=0 → pc_beq_o=0 and no bubbles.
- bne 0x1509_0002 with zero_m_i=0 → pc_beq_o=1; with zero_m_i=1 → 0.
- stall_d_i=1 for one cycle while instr_d_i=R-type add 0x012A_4020 → E bubble once; add bundle appears in E the following cycle. Stall together with flush_e_i → still a single bubble.
- sll 0x0009_4880 → apply_shift_e=1, reg_dst=1. j 0x0800_0010 → pc_j_o=1 in D and a bubble in E. Opcode 0x3F → illegal_d_o=1 and a bubble.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode/funct constants and pipelined control bundles
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALT_FUNCT = 2'b00,
    ALT_ADD   = 2'b01,
    ALT_SUB   = 2'b10,
    ALT_RSVD  = 2'b11
  } alt_ctrl_e;

  typedef struct packed {
    logic wreg;
    logic mem_to_reg;
  } ctrl_w_t;

  typedef struct packed {
    logic    mem_write;
    logic    branch;
    logic    bne;
    ctrl_w_t w;
  } ctrl_m_t;

  typedef struct packed {
    logic      reg_dst;
    logic      b_alu;
    logic      apply_shift;
    alt_ctrl_e alt;
    ctrl_m_t   m;
  } ctrl_e_t;

  localparam ctrl_w_t W_BUBBLE = '0;
  localparam ctrl_m_t M_BUBBLE = '0;
  localparam ctrl_e_t E_BUBBLE = '0;

endpackage

// File: rtl/main_dec.sv
// rtl/main_dec.sv - combinational opcode/funct decoder producing the full control bundle
module main_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output ctrl_e_t    ctrl_o,
  output logic       jump_o,
  output logic       illegal_o
);

  // Anything not explicitly decoded leaves the bundle as a bubble.
  always_comb begin
    ctrl_o    = E_BUBBLE;
    jump_o    = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_SLL, FN_SRL: begin
            ctrl_o.reg_dst     = 1'b1;
            ctrl_o.apply_shift = 1'b1;
            ctrl_o.m.w.wreg    = 1'b1;
          end
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            ctrl_o.reg_dst  = 1'b1;
            ctrl_o.m.w.wreg = 1'b1;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl_o.b_alu          = 1'b1;
        ctrl_o.alt            = ALT_ADD;
        ctrl_o.m.w.wreg       = 1'b1;
        ctrl_o.m.w.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl_o.b_alu       = 1'b1;
        ctrl_o.alt         = ALT_ADD;
        ctrl_o.m.mem_write = 1'b1;
      end
      OP_ADDI: begin
        ctrl_o.b_alu    = 1'b1;
        ctrl_o.alt      = ALT_ADD;
        ctrl_o.m.w.wreg = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_o.alt      = ALT_SUB;
        ctrl_o.m.branch = 1'b1;
        ctrl_o.m.bne    = (op_i == OP_BNE);
      end
      OP_J:    jump_o    = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - D->E->M->W control pipeline with M-stage branch resolution
module pipe_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instr_d_i,
  input  logic        zero_m_i,
  input  logic        stall_d_i,
  input  logic        flush_e_i,
  output logic        pc_j_o,
  output logic        reg_dst_rtrd_e_o,
  output logic        b_alu_input_e_o,
  output logic        apply_shift_e_o,
  output logic [1:0]  alu_alt_ctrl_e_o,
  output logic        mem_write_m_o,
  output logic        pc_beq_o,
  output logic        enable_wreg_w_o,
  output logic        mem_to_reg_w_o,
  output logic        illegal_d_o
);

  ctrl_e_t dec_ctrl;
  ctrl_e_t ctrl_e_d, ctrl_e_q;
  ctrl_m_t ctrl_m_d, ctrl_m_q;
  ctrl_w_t ctrl_w_d, ctrl_w_q;
  logic    taken;
  logic    unused_instr;

  assign unused_instr = ^instr_d_i[25:6];

  main_dec u_main_dec (
    .op_i      (instr_d_i[31:26]),
    .funct_i   (instr_d_i[5:0]),
    .ctrl_o    (dec_ctrl),
    .jump_o    (pc_j_o),
    .illegal_o (illegal_d_o)
  );

  assign taken = ctrl_m_q.branch & (zero_m_i ^ ctrl_m_q.bne);

  // A taken branch squashes the two younger instructions already in D and E.
  always_comb begin
    ctrl_e_d = dec_ctrl;
    ctrl_m_d = ctrl_e_q.m;
    ctrl_w_d = ctrl_m_q.w;
    if (stall_d_i || flush_e_i || taken) ctrl_e_d = E_BUBBLE;
    if (taken)                          ctrl_m_d = M_BUBBLE;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ctrl_e_q <= E_BUBBLE;
      ctrl_m_q <= M_BUBBLE;
      ctrl_w_q <= W_BUBBLE;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      ctrl_m_q <= ctrl_m_d;
      ctrl_w_q <= ctrl_w_d;
    end
  end

  assign reg_dst_rtrd_e_o = ctrl_e_q.reg_dst;
  assign b_alu_input_e_o  = ctrl_e_q.b_alu;
  assign apply_shift_e_o  = ctrl_e_q.apply_shift;
  assign alu_alt_ctrl_e_o = ctrl_e_q.alt;
  assign mem_write_m_o    = ctrl_m_q.mem_write;
  assign pc_beq_o         = taken;
  assign enable_wreg_w_o  = ctrl_w_q.wreg;
  assign mem_to_reg_w_o   = ctrl_w_q.mem_to_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] instr;
  logic        zero, stall, flush;
  logic        pc_j, reg_dst, b_alu, shift, memw, pc_beq, wreg, m2r, illegal;
  logic [1:0]  alt;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADDI = 32'h2008_0005;
  localparam logic [31:0] I_LW   = 32'h8C09_0004;
  localparam logic [31:0] I_SW   = 32'hAC09_0008;
  localparam logic [31:0] I_BEQ  = 32'h1109_0002;
  localparam logic [31:0] I_BNE  = 32'h1509_0002;
  localparam logic [31:0] I_ADD  = 32'h012A_4020;
  localparam logic [31:0] I_SLL  = 32'h0009_4880;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_FILL = 32'hFC00_0000;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .instr_d_i        (instr),
    .zero_m_i         (zero),
    .stall_d_i        (stall),
    .flush_e_i        (flush),
    .pc_j_o           (pc_j),
    .reg_dst_rtrd_e_o (reg_dst),
    .b_alu_input_e_o  (b_alu),
    .apply_shift_e_o  (shift),
    .alu_alt_ctrl_e_o (alt),
    .mem_write_m_o    (memw),
    .pc_beq_o         (pc_beq),
    .enable_wreg_w_o  (wreg),
    .mem_to_reg_w_o   (m2r),
    .illegal_d_o      (illegal)
  );

  typedef struct packed {
    logic       reg_dst, b_alu, shift;
    logic [1:0] alt;
    logic       memw, branch, bne, wreg, m2r;
  } bnd_t;

  typedef struct {
    logic [31:0] instr;
    logic        pc_j, illegal, reg_dst, b_alu, shift;
    logic [1:0]  alt;
  } vec_t;

  bnd_t me, mm, mw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit r_funct_ok(input int fn);
    return fn == 0 || fn == 2 || fn == 32 || fn == 34 || fn == 36 || fn == 37 || fn == 42;
  endfunction

  function automatic logic ref_illegal(input logic [31:0] ins);
    int op = int'(ins[31:26]);
    if (op == 0) return !r_funct_ok(int'(ins[5:0]));
    return !(op == 2 || op == 4 || op == 5 || op == 8 || op == 35 || op == 43);
  endfunction

  function automatic bnd_t ref_dec(input logic [31:0] ins);
    bnd_t b = '0;
    int op = int'(ins[31:26]);
    int fn = int'(ins[5:0]);
    if (op == 0 && r_funct_ok(fn)) begin
      b.reg_dst = 1'b1;
      b.wreg    = 1'b1;
      b.shift   = (fn == 0 || fn == 2);
    end else if (op == 35) begin
      b.b_alu = 1'b1; b.alt = 2'd1; b.wreg = 1'b1; b.m2r = 1'b1;
    end else if (op == 43) begin
      b.b_alu = 1'b1; b.alt = 2'd1; b.memw = 1'b1;
    end else if (op == 8) begin
      b.b_alu = 1'b1; b.alt = 2'd1; b.wreg = 1'b1;
    end else if (op == 4 || op == 5) begin
      b.alt = 2'd2; b.branch = 1'b1; b.bne = (op == 5);
    end
    return b;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [5:0]  ops [7] = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd35, 6'd43};
    logic [5:0]  fns [8] = '{6'd0, 6'd2, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd63};
    logic [31:0] r = $urandom;
    if ($urandom_range(0, 4) == 0) return r;
    return {ops[$urandom_range(0, 6)], r[25:6], fns[$urandom_range(0, 7)]};
  endfunction

  task automatic check_model(input string tag);
    logic taken = mm.branch & (zero ^ mm.bne);
    chk({tag, ".pc_j"},    pc_j,    instr[31:26] == 6'd2);
    chk({tag, ".illegal"}, illegal, ref_illegal(instr));
    chk({tag, ".reg_dst"}, reg_dst, me.reg_dst);
    chk({tag, ".b_alu"},   b_alu,   me.b_alu);
    chk({tag, ".shift"},   shift,   me.shift);
    chk({tag, ".alt"},     alt,     me.alt);
    chk({tag, ".memw"},    memw,    mm.memw);
    chk({tag, ".pc_beq"},  pc_beq,  taken);
    chk({tag, ".wreg"},    wreg,    mw.wreg);
    chk({tag, ".m2r"},     m2r,     mw.m2r);
  endtask

  vec_t vecs[11];

  initial begin
    bnd_t ne, nm, nw;
    logic tk;

    vecs[0]  = '{I_ADDI,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01};
    vecs[1]  = '{I_LW,          1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01};
    vecs[2]  = '{I_SW,          1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01};
    vecs[3]  = '{I_BEQ,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
    vecs[4]  = '{I_BNE,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
    vecs[5]  = '{I_ADD,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[6]  = '{I_SLL,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[7]  = '{32'h0009_4882, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[8]  = '{I_J,           1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[9]  = '{I_FILL,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[10] = '{32'h0000_003F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};

    reset_i = 1'b0; instr = I_ADDI; zero = 1'b0; stall = 1'b0; flush = 1'b0;
    #1;
    chk("rst.b_alu", b_alu, 1'b0);
    chk("rst.alt", alt, 2'b00);
    chk("rst.wreg", wreg, 1'b0);
    chk("rst.memw", memw, 1'b0);
    chk("rst.pc_beq", pc_beq, 1'b0);
    chk("rst.illegal", illegal, 1'b0);
    tick(); tick();
    chk("rst_hold.b_alu", b_alu, 1'b0);
    chk("rst_hold.wreg", wreg, 1'b0);

    reset_i = 1'b1;
    tick();
    instr = I_FILL;
    chk("addi.e.b_alu", b_alu, 1'b1);
    chk("addi.e.alt", alt, 2'b01);
    chk("addi.e.reg_dst", reg_dst, 1'b0);
    tick();
    chk("addi.m.memw", memw, 1'b0);
    tick();
    chk("addi.w.wreg", wreg, 1'b1);
    chk("addi.w.m2r", m2r, 1'b0);

    instr = I_LW;   tick();
    instr = I_SW;   tick();
    instr = I_FILL; tick();
    chk("lw.w.wreg", wreg, 1'b1);
    chk("lw.w.m2r", m2r, 1'b1);
    chk("sw.m.memw", memw, 1'b1);
    tick();
    chk("sw.w.wreg", wreg, 1'b0);
    chk("sw.w.m2r", m2r, 1'b0);
    chk("fill.m.memw", memw, 1'b0);

    instr = I_BEQ; tick();
    instr = I_ADD; tick();
    zero = 1'b1;
    #1;
    chk("beq.taken", pc_beq, 1'b1);
    tick();
    instr = I_FILL;
    chk("beq.e_bubble", reg_dst, 1'b0);
    chk("beq.m_bubble", pc_beq, 1'b0);
    chk("beq.w.wreg", wreg, 1'b0);
    tick();
    chk("beq.squashed.wreg", wreg, 1'b0);
    tick();
    instr = I_BEQ; zero = 1'b0; tick();
    instr = I_ADD; tick();
    #1;
    chk("beq.not_taken", pc_beq, 1'b0);
    tick();
    instr = I_FILL;
    chk("beq_nt.e.reg_dst", reg_dst, 1'b1);
    tick();
    tick();
    chk("beq_nt.add.w.wreg", wreg, 1'b1);

    instr = I_BNE; tick();
    instr = I_FILL; tick();
    zero = 1'b0; #1;
    chk("bne.zero0", pc_beq, 1'b1);
    zero = 1'b1; #1;
    chk("bne.zero1", pc_beq, 1'b0);
    tick();
    zero = 1'b0;

    instr = I_ADD; stall = 1'b1; tick();
    chk("stall.e_bubble", reg_dst, 1'b0);
    stall = 1'b0; tick();
    chk("stall.e_add", reg_dst, 1'b1);
    stall = 1'b1; flush = 1'b1; tick();
    chk("stall_flush.e_bubble", reg_dst, 1'b0);
    stall = 1'b0; flush = 1'b0; tick();
    chk("stall_flush.e_add", reg_dst, 1'b1);
    instr = I_FILL; tick();

    foreach (vecs[i]) begin
      reset_i = 1'b0;
      #1;
      reset_i = 1'b1;
      instr = vecs[i].instr;
      #1;
      chk($sformatf("vec%0d.pc_j", i), pc_j, vecs[i].pc_j);
      chk($sformatf("vec%0d.illegal", i), illegal, vecs[i].illegal);
      tick();
      chk($sformatf("vec%0d.reg_dst", i), reg_dst, vecs[i].reg_dst);
      chk($sformatf("vec%0d.b_alu", i), b_alu, vecs[i].b_alu);
      chk($sformatf("vec%0d.shift", i), shift, vecs[i].shift);
      chk($sformatf("vec%0d.alt", i), alt, vecs[i].alt);
    end

    me = '0; mm = '0; mw = '0;
    for (int i = 0; i < 1500; i++) begin
      reset_i = !(i == 0 || $urandom_range(0, 63) == 0);
      instr   = gen_instr();
      stall   = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      zero    = 1'($urandom_range(0, 1));
      if (!reset_i) begin
        me = '0; mm = '0; mw = '0;
      end
      #1;
      check_model($sformatf("rnd%0d", i));
      tk = mm.branch & (zero ^ mm.bne);
      nw = mm;
      nm = tk ? '0 : me;
      ne = (stall || flush || tk) ? '0 : ref_dec(instr);
      if (!reset_i) begin
        ne = '0; nm = '0; nw = '0;
      end
      @(posedge clk);
      me = ne; mm = nm; mw = nw;
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
